// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus seen by the UART TX peripheral: the core drives address, data and
// write enable, and the peripheral answers with read data and its window hit flag.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, output wdata, output we, input rdata, input hit);
    modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: software pushes bytes into a TX FIFO through
// a 16-byte register window, and a four-state FSM shifts them out LSB first on tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [15:0]      bit_cnt, bit_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;

    logic [15:0]      baud_div;
    logic             ctrl_enable, ctrl_irq_en;
    logic             overflow;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty, fifo_full;

    logic [1:0]       reg_sel;
    logic             wr_en, push, push_ok, pop, busy;
    logic             unused_bits;

    assign bus.hit    = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = bus.addr[3:2];
    assign wr_en      = bus.hit & bus.we;
    assign push       = wr_en && (reg_sel == 2'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    // A push into a full FIFO still fits if the FSM pops the head on the same edge.
    assign push_ok    = push & (~fifo_full | pop);
    assign busy       = (state != IDLE);
    assign irq        = ctrl_irq_en & fifo_empty & ~busy;
    assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

    always_comb begin
        bus.rdata = '0;
        if (bus.hit) begin
            case (reg_sel)
                2'd1:    bus.rdata = {16'h0, 8'(count), 4'h0, overflow, fifo_empty, fifo_full, busy};
                2'd2:    bus.rdata = {16'h0, baud_div};
                2'd3:    bus.rdata = {30'h0, ctrl_irq_en, ctrl_enable};
                default: bus.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_div    <= DEFAULT_DIV;
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en && reg_sel == 2'd2)
                baud_div <= (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
            if (wr_en && reg_sel == 2'd3) begin
                ctrl_enable <= bus.wdata[0];
                ctrl_irq_en <= bus.wdata[1];
            end
            // A dropped push on the same edge as a W1C keeps the flag set.
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (wr_en && reg_sel == 2'd1 && bus.wdata[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // Each bit period reloads its counter from the live BAUD_DIV, so divisor writes
    // land at the next bit boundary; tx is derived from the next state so it is registered.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_enable && !fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    bit_cnt_next = baud_div - 16'd1;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_cnt == 16'd0) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    bit_cnt_next = baud_div - 16'd1;
                end else begin
                    bit_cnt_next = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == 16'd0) begin
                    bit_cnt_next = baud_div - 16'd1;
                    shift_next   = shift >> 1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx + 3'd1;
                end else begin
                    bit_cnt_next = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == 16'd0) begin
                    if (ctrl_enable && !fifo_empty) begin
                        pop          = 1'b1;
                        shift_next   = fifo_mem[rd_ptr];
                        bit_cnt_next = baud_div - 16'd1;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed register accesses plus a serial-line monitor that
// checks every transmitted frame, cycle by cycle, against a queue of expected frames.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_BAUD   = 32'h8;
    localparam logic [31:0] OFF_CTRL   = 32'hC;

    typedef struct packed {
        logic [7:0]       data;
        logic [9:0][15:0] len;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx, irq;

    frame_t exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    logic   mon_en      = 1'b1;
    logic   mon_busy    = 1'b0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
    endtask

    task automatic applyStimulus(input logic [31:0] off, input logic [31:0] d);
        busWrite(BASE + off, d);
    endtask

    task automatic checkReg(input string name, input logic [31:0] off, input logic [31:0] expected);
        logic [31:0] d;
        bus.we   = 1'b0;
        bus.addr = BASE + off;
        #1;
        d = bus.rdata;
        bus.addr = 32'h0;
        checkOutput(name, d, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectFrame(input logic [7:0] d, input int div);
        frame_t f;
        f.data = d;
        for (int k = 0; k < 10; k++) f.len[k] = 16'(div);
        exp_q.push_back(f);
    endtask

    // Serial-line monitor: each bit must hold its expected level for exactly its length.
    initial begin : monitor
        frame_t f;
        logic   exp_bit, act_bit, ok, aborted;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame_start", 32'(tx), 32'd1);
                end else begin
                    f = exp_q.pop_front();
                    aborted = 1'b0;
                    for (int k = 0; k < 10 && !aborted; k++) begin
                        exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.data[k-1];
                        act_bit = exp_bit;
                        ok      = 1'b1;
                        for (int c = 0; c < int'(f.len[k]); c++) begin
                            if (!(k == 0 && c == 0)) @(negedge clk);
                            if (!mon_en) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== exp_bit) begin
                                ok      = 1'b0;
                                act_bit = tx;
                            end
                        end
                        if (!aborted)
                            checkOutput($sformatf("frame_%02h_bit%0d", f.data, k), 32'(act_bit), 32'(exp_bit));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("[TB] FAIL watchdog: run still active at %0t, required completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        frame_t f;
        int     busy_cycles;
        logic [31:0] st;

        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.we    = 1'b0;

        // Reset state and address decode
        waitCycles(3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkReg("reset_status", OFF_STATUS, 32'h0000_0004);
        checkReg("reset_baud", OFF_BAUD, 32'd868);
        checkReg("reset_ctrl", OFF_CTRL, 32'h0);
        checkReg("txdata_reads_zero", OFF_TXDATA, 32'h0);
        bus.addr = BASE + OFF_STATUS;
        #1;
        checkOutput("hit_in_window", 32'(bus.hit), 32'd1);
        bus.addr = BASE + 32'h10;
        #1;
        checkOutput("hit_outside_window", 32'(bus.hit), 32'd0);
        checkOutput("rdata_outside_window", bus.rdata, 32'h0);
        busWrite(BASE + 32'h1C, 32'h3);
        busWrite(32'h2000_0000, 32'h11);
        checkReg("ctrl_after_miss_write", OFF_CTRL, 32'h0);
        checkReg("status_after_miss_write", OFF_STATUS, 32'h0000_0004);

        // Single frame with a 4-cycle bit period
        applyStimulus(OFF_BAUD, 32'd4);
        applyStimulus(OFF_CTRL, 32'd1);
        expectFrame(8'hA5, 4);
        applyStimulus(OFF_TXDATA, 32'hA5);
        checkOutput("tx_high_at_push_edge", 32'(tx), 32'd1);
        waitCycles(1);
        checkOutput("tx_low_after_pop_edge", 32'(tx), 32'd0);
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            checkReg("status_poll", OFF_STATUS, 32'(busy_cycles < 40 ? 32'h5 : 32'h4));
            bus.addr = BASE + OFF_STATUS;
            #1;
            st = bus.rdata;
            bus.addr = 32'h0;
            if (st[0]) busy_cycles++;
            else break;
            waitCycles(1);
        end
        checkOutput("single_frame_busy_cycles", 32'(busy_cycles), 32'd40);
        checkOutput("irq_masked", 32'(irq), 32'd0);

        // Back-to-back frames queued while disabled
        applyStimulus(OFF_BAUD, 32'd2);
        applyStimulus(OFF_CTRL, 32'd0);
        expectFrame(8'h55, 2);
        expectFrame(8'h0F, 2);
        applyStimulus(OFF_TXDATA, 32'h55);
        applyStimulus(OFF_TXDATA, 32'h0F);
        checkReg("b2b_queued", OFF_STATUS, 32'h0000_0200);
        applyStimulus(OFF_CTRL, 32'd1);
        waitCycles(1);
        checkReg("b2b_first_start", OFF_STATUS, 32'h0000_0101);
        waitCycles(19);
        checkReg("b2b_first_stop", OFF_STATUS, 32'h0000_0101);
        waitCycles(1);
        checkReg("b2b_second_start", OFF_STATUS, 32'h0000_0005);
        waitCycles(19);
        checkReg("b2b_second_stop", OFF_STATUS, 32'h0000_0005);
        waitCycles(1);
        checkReg("b2b_done", OFF_STATUS, 32'h0000_0004);

        // Overflow, W1C, and a push into a full FIFO on a pop edge
        applyStimulus(OFF_CTRL, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) expectFrame(8'(i), 2);
            applyStimulus(OFF_TXDATA, 32'(i));
        end
        checkReg("overflow_status", OFF_STATUS, 32'h0000_080A);
        applyStimulus(OFF_STATUS, 32'h7);
        checkReg("status_other_bits_ignored", OFF_STATUS, 32'h0000_080A);
        applyStimulus(OFF_STATUS, 32'h8);
        checkReg("overflow_cleared", OFF_STATUS, 32'h0000_0802);
        expectFrame(8'h99, 2);
        applyStimulus(OFF_CTRL, 32'd1);
        applyStimulus(OFF_TXDATA, 32'h99);
        checkReg("push_full_with_pop", OFF_STATUS, 32'h0000_0803);
        waitCycles(185);
        checkReg("overflow_drained", OFF_STATUS, 32'h0000_0004);

        // Divisor change mid-DATA and interrupt on final stop
        applyStimulus(OFF_BAUD, 32'd4);
        applyStimulus(OFF_CTRL, 32'd3);
        checkOutput("irq_idle_empty", 32'(irq), 32'd1);
        f.data = 8'h3C;
        for (int k = 0; k < 10; k++) f.len[k] = (k < 2) ? 16'd4 : 16'd1;
        exp_q.push_back(f);
        applyStimulus(OFF_TXDATA, 32'h3C);
        checkOutput("irq_low_fifo_nonempty", 32'(irq), 32'd0);
        waitCycles(5);
        applyStimulus(OFF_BAUD, 32'd0);
        checkReg("baud_zero_stored_as_one", OFF_BAUD, 32'd1);
        waitCycles(10);
        checkOutput("irq_low_in_stop", 32'(irq), 32'd0);
        waitCycles(1);
        checkOutput("irq_after_stop", 32'(irq), 32'd1);

        // Reset in the middle of a frame
        mon_en = 1'b0;
        applyStimulus(OFF_BAUD, 32'd4);
        applyStimulus(OFF_CTRL, 32'd1);
        applyStimulus(OFF_TXDATA, 32'h00);
        applyStimulus(OFF_TXDATA, 32'h81);
        waitCycles(9);
        checkOutput("tx_low_before_reset", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("tx_async_reset", 32'(tx), 32'd1);
        checkOutput("irq_in_reset", 32'(irq), 32'd0);
        waitCycles(2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkReg("status_after_midframe_reset", OFF_STATUS, 32'h0000_0004);
        checkReg("baud_after_midframe_reset", OFF_BAUD, 32'd868);
        checkReg("ctrl_after_midframe_reset", OFF_CTRL, 32'h0);
        mon_en = 1'b1;
        applyStimulus(OFF_CTRL, 32'd1);
        waitCycles(20);
        checkReg("no_residual_frame", OFF_STATUS, 32'h0000_0004);
        checkOutput("tx_idle_final", 32'(tx), 32'd1);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("monitor_idle", 32'(mon_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
